// File: rtl/lowpass_decimator_pkg.sv
// Shared types and default widths for the lowpass decimator.
// The beat struct is the unit carried through the output skid buffer.
package lowpass_decimator_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int USER_W_DEF = 2;
  localparam int RATE_W_DEF = 8;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [USER_W_DEF-1:0] user;
    logic                  last;
  } axis_beat_t;

  localparam int BEAT_W_DEF = $bits(axis_beat_t);

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output stage: registered main beat plus one spare.
// Ready is registered and means "spare empty".
module axis_skid_buffer
  import lowpass_decimator_pkg::*;
#(
  parameter int W = BEAT_W_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] in_beat,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_beat,
  input  logic         out_ready
);

  logic         sp_v, sp_v_n;
  logic [W-1:0] sp_d, sp_d_n;
  logic         m_v_n;
  logic [W-1:0] m_d_n;
  logic         pop;

  assign pop = out_valid & out_ready;

  always_comb begin
    m_v_n  = out_valid;
    m_d_n  = out_beat;
    sp_v_n = sp_v;
    sp_d_n = sp_d;
    if (sp_v) begin
      if (pop) begin
        m_d_n  = sp_d;
        sp_v_n = 1'b0;
      end
    end else if (push) begin
      // Reload main with no bubble when it is empty or being popped.
      if (!out_valid || pop) begin
        m_v_n = 1'b1;
        m_d_n = in_beat;
      end else begin
        sp_v_n = 1'b1;
        sp_d_n = in_beat;
      end
    end else if (pop) begin
      m_v_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
      sp_v      <= 1'b0;
      sp_d      <= '0;
      in_ready  <= 1'b0;
    end else begin
      out_valid <= m_v_n;
      out_beat  <= m_d_n;
      sp_v      <= sp_v_n;
      sp_d      <= sp_d_n;
      in_ready  <= !sp_v_n;
    end
  end

endmodule

// File: rtl/lowpass_decimator.sv
// Keeps every N-th filtered sample; tlast and tuser changes force emission.
// Phase, rate and tag tracking live here; buffering is in the skid.
module lowpass_decimator
  import lowpass_decimator_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int USER_W = USER_W_DEF,
  parameter int RATE_W = RATE_W_DEF
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_arstn,
  input  logic [RATE_W-1:0] dec_rate,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast
);

  localparam int BW = DATA_W + USER_W + 1;

  logic [RATE_W-1:0] ph, ph_n;
  logic [RATE_W-1:0] rate_q, dec_eff, n_cur;
  logic [USER_W-1:0] prev_user;
  logic              prev_ok;
  logic              accept, tag_chg, win, emit;
  logic [BW-1:0]     in_beat, out_beat;

  assign accept  = s_axis_tvalid & s_axis_tready;
  assign dec_eff = (dec_rate == '0) ? RATE_W'(1) : dec_rate;
  assign tag_chg = prev_ok & (s_axis_tuser != prev_user);
  assign win     = (ph == '0) | tag_chg;
  assign n_cur   = win ? dec_eff : rate_q;
  assign emit    = (ph == '0) | s_axis_tlast | tag_chg;

  always_comb begin
    ph_n = ph + RATE_W'(1);
    unique case (1'b1)
      s_axis_tlast:
        ph_n = '0;
      tag_chg:
        ph_n = (n_cur == RATE_W'(1)) ? '0 : RATE_W'(1);
      (ph == n_cur - RATE_W'(1)):
        ph_n = '0;
      default:
        ph_n = ph + RATE_W'(1);
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_arstn) begin
      ph        <= '0;
      rate_q    <= RATE_W'(1);
      prev_user <= '0;
      prev_ok   <= 1'b0;
    end else if (accept) begin
      ph        <= ph_n;
      prev_user <= s_axis_tuser;
      prev_ok   <= 1'b1;
      if (win) rate_q <= dec_eff;
    end
  end

  assign in_beat = {s_axis_tdata, s_axis_tuser, s_axis_tlast};

  axis_skid_buffer #(.W(BW)) u_skid (
    .clk       (s_axis_aclk),
    .rstn      (s_axis_arstn),
    .push      (accept & emit),
    .in_beat   (in_beat),
    .in_ready  (s_axis_tready),
    .out_valid (m_axis_tvalid),
    .out_beat  (out_beat),
    .out_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tuser, m_axis_tlast} = out_beat;

endmodule

// File: tb/tb_lowpass_decimator.sv
// Directed bench for lowpass_decimator with a capture queue
// compared against hand-computed expected beats.
module tb_lowpass_decimator;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic [7:0]  dec_rate = 8'd4;
  logic [23:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [1:0]  s_tuser = '0;
  logic        s_tlast = 1'b0;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [1:0]  m_tuser;
  logic        m_tlast;

  int errs = 0;
  int checks = 0;

  logic [26:0] exp_q[$];
  logic [26:0] got_q[$];
  logic        stall_prev = 1'b0;
  logic [26:0] prev_beat = '0;

  always #5 clk = ~clk;

  lowpass_decimator dut (
    .s_axis_aclk   (clk),
    .s_axis_arstn  (arstn),
    .dec_rate      (dec_rate),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (arstn && m_tvalid && m_tready)
      got_q.push_back({m_tdata, m_tuser, m_tlast});
    if (arstn && stall_prev) begin
      check("hold_valid", {31'd0, m_tvalid}, 32'd1);
      check("hold_beat", {5'd0, m_tdata, m_tuser, m_tlast},
            {5'd0, prev_beat});
    end
    stall_prev = arstn & m_tvalid & !m_tready;
    prev_beat  = {m_tdata, m_tuser, m_tlast};
  end

  task automatic send(input int d, input logic [1:0] u, input logic l);
    bit done;
    done = 1'b0;
    s_tdata  = d[23:0];
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (s_tready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_beat(input int d, input logic [1:0] u,
                             input logic l);
    exp_q.push_back({d[23:0], u, l});
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    arstn    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_q(input string tag);
    s_tvalid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, {5'd0, got_q[i]}, {5'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    @(posedge clk);
    #1;
    check("rst_tready", {31'd0, s_tready}, 32'd0);
    check("rst_mvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_beat", {5'd0, m_tdata, m_tuser, m_tlast}, 32'd0);
    arstn = 1'b1;
    @(posedge clk);
    #1;
    check("tready_after_rst", {31'd0, s_tready}, 32'd1);

    dec_rate = 8'd4;
    for (int i = 0; i < 12; i++) begin
      send(i, 2'd0, 1'b0);
      if (i % 4 == 0) begin
        expect_beat(i, 2'd0, 1'b0);
        check("lat_valid", {31'd0, m_tvalid}, 32'd1);
        check("lat_data", {8'd0, m_tdata}, i);
      end
    end
    cmp_q("n4_plain");

    do_reset();
    for (int i = 0; i < 12; i++) send(i, 2'd0, i == 6);
    expect_beat(0, 2'd0, 1'b0);
    expect_beat(4, 2'd0, 1'b0);
    expect_beat(6, 2'd0, 1'b1);
    expect_beat(7, 2'd0, 1'b0);
    expect_beat(11, 2'd0, 1'b0);
    cmp_q("n4_tlast");

    do_reset();
    dec_rate = 8'd3;
    for (int i = 0; i < 9; i++) send(i, (i < 4) ? 2'd0 : 2'd2, 1'b0);
    expect_beat(0, 2'd0, 1'b0);
    expect_beat(3, 2'd0, 1'b0);
    expect_beat(4, 2'd2, 1'b0);
    expect_beat(7, 2'd2, 1'b0);
    cmp_q("n3_tuser");

    for (int r = 0; r < 2; r++) begin
      do_reset();
      dec_rate = r[7:0];
      for (int i = 0; i < 16; i++) begin
        send(i, 2'd1, 1'b0);
        expect_beat(i, 2'd1, 1'b0);
      end
      cmp_q(r == 0 ? "rate0" : "rate1");
    end

    do_reset();
    dec_rate = 8'd1;
    m_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(i + 100, 2'd0, 1'b0);
          expect_beat(i + 100, 2'd0, 1'b0);
        end
        s_tvalid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        check("stall_tready", {31'd0, s_tready}, 32'd0);
        check("stall_valid", {31'd0, m_tvalid}, 32'd1);
        check("stall_data", {8'd0, m_tdata}, 32'd100);
        repeat (14) @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    cmp_q("stall");

    do_reset();
    dec_rate = 8'd4;
    send(0, 2'd0, 1'b0);
    send(1, 2'd0, 1'b0);
    dec_rate = 8'd2;
    for (int i = 2; i < 9; i++) send(i, 2'd0, 1'b0);
    s_tvalid = 1'b0;
    expect_beat(0, 2'd0, 1'b0);
    expect_beat(4, 2'd0, 1'b0);
    expect_beat(6, 2'd0, 1'b0);
    expect_beat(8, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    arstn = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_tready", {31'd0, s_tready}, 32'd0);
    check("mid_rst_valid", {31'd0, m_tvalid}, 32'd0);
    arstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_tready", {31'd0, s_tready}, 32'd1);
    send(20, 2'd3, 1'b0);
    s_tvalid = 1'b0;
    expect_beat(20, 2'd3, 1'b0);
    check("post_rst_valid", {31'd0, m_tvalid}, 32'd1);
    check("post_rst_data", {8'd0, m_tdata}, 32'd20);
    @(posedge clk);
    #1;
    check("post_rst_empty", {31'd0, m_tvalid}, 32'd0);
    check("post_rst_rdy", {31'd0, s_tready}, 32'd1);
    cmp_q("rate_chg_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/lowpass_decimator.md
# lowpass_decimator

Sample-rate reducer that sits directly downstream of `lowpass_fir` in the sonar receive chain. It consumes the filtered 24-bit AXI-Stream and forwards every N-th sample, where N is set at run time. Frame boundaries (`tlast`) and channel/mode tags (`tuser`) are preserved exactly. The output is registered and backed by a skid buffer, so it sustains full throughput under arbitrary `m_axis_tready` patterns.

## Interface
- `DATA_W`, 24, sample width (matches `lowpass_fir` output)
- `USER_W`, 2, `tuser` width (mode/channel tag)
- `RATE_W`, 8, width of decimation-factor input
- `s_axis_aclk`  in  1  sole clock
- `s_axis_arstn`  in  1  reset; synchronous, active-low
- `dec_rate`  in  RATE_W  decimation factor N; 0 is treated as 1
- `s_axis_tdata`  in  DATA_W  filtered sample
- `s_axis_tvalid`  in  1  input valid
- `s_axis_tready`  out  1  input ready
- `s_axis_tuser`  in  USER_W  mode tag
- `s_axis_tlast`  in  1  end of frame
- `m_axis_tdata`  out  DATA_W  decimated sample
- `m_axis_tvalid`  out  1  output valid
- `m_axis_tready`  in  1  output ready
- `m_axis_tuser`  out  USER_W  tag of the emitted sample
- `m_axis_tlast`  out  1  end of frame on output

## Operation
- A phase counter `ph` (RATE_W bits) advances on every accepted input beat (`tvalid & tready`).
- A beat is emitted when any of the following holds:
  - `ph == 0`, which is the first sample of a window;
  - `s_axis_tlast == 1`;
  - `s_axis_tuser` differs from the tag of the previously accepted beat.
- All other beats are dropped. An emitted beat carries its own data, user and last fields unchanged.
- Counter update:
  - If the beat has `tlast`, `ph` is set to 0, so the next beat starts a fresh window.
  - If the beat has a `tuser` change, it is treated as window start and `ph` is set to 1 (or 0 if N = 1).
  - Otherwise, if `ph == N-1`, `ph` wraps to 0; else `ph` increments.
- `N` is latched into `rate_q` only when a beat is accepted at window start. A change to `dec_rate` mid-window takes effect at the next window.
- N = 0 or N = 1 gives pass-through: every beat is emitted.
- The first beat after reset is always a window start. The previous-tag register resets to 0 and is flagged invalid, so the first beat never counts as a `tuser` change.
- Arithmetic is unsigned and there are no data-path operations. `tdata` is never modified.

## Timing
- Reset values: `s_axis_tready` = 0; `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tuser` and `m_axis_tlast` = 0; `ph` = 0; skid buffer empty.
- `s_axis_tready` goes high on the first cycle after `s_axis_arstn` is released.
- Latency is 1 cycle: an emitted beat accepted at edge k has `m_axis_tvalid` = 1 after edge k.
- `s_axis_tready` is registered and equals "skid buffer not full". The output stage is a 2-entry skid (main register plus spare):
  - A beat accepted while the output is stalled goes to the spare.
  - `s_axis_tready` drops the cycle after the spare fills.
  - `s_axis_tready` rises the cycle after the spare drains.
- Dropped beats also require `s_axis_tready`, so backpressure throttles the input uniformly.
- Simultaneous output pop and input push with the spare empty: the main register is reloaded with no bubble. Sustained throughput is 1 beat per cycle.
- Once `m_axis_tvalid` is asserted, `m_axis_tdata`, `m_axis_tuser` and `m_axis_tlast` stay stable until `m_axis_tready`.
- Reset mid-operation: all buffered beats are discarded and the block returns to the reset state on the next edge. No partial beat is emitted.

## Structure
- Package `lowpass_decimator_pkg` holds:
  - `DATA_W`, `USER_W` and `RATE_W` defaults;
  - `typedef struct packed { logic [DATA_W-1:0] data; logic [USER_W-1:0] user; logic last; } axis_beat_t`.
- Sub-module `axis_skid_buffer`, parameterised on the `axis_beat_t` width, implements the output register and spare. The decimator keeps only the phase, rate and tag logic.

## Test plan
- N=4, inputs 0..11 with constant `tuser`, no `tlast`, `m_axis_tready`=1 → outputs 0, 4, 8; each appears 1 cycle after its input is accepted.
- N=4, inputs 0..11, `tlast` on 6 → outputs 0, 4, 6 (`tlast`=1), 7, 11.
- N=3, inputs 0..8, `tuser` 0 for 0..3 and 2 for 4..8 → outputs 0 (user 0), 3 (user 0), 4 (user 2), 7 (user 2).
- `dec_rate`=0, then `dec_rate`=1, inputs 0..15 → all 16 beats emitted in order in both cases.
- N=1, continuous input, `m_axis_tready` low for 20 cycles → `s_axis_tready` low after 2 beats are held; no loss or duplication; outputs stay stable while stalled; order preserved after release.
- N=4, `dec_rate` changed to 2 at input 2, then `s_axis_arstn` pulsed low at input 9 → output 0 before the rate takes effect, then 4, 6, 8. After reset, the first accepted beat is emitted and the skid buffer is empty.
